// File: rtl/serial_nibble_matcher_pkg.sv
// ============================================================================
// Module      : nibble_pkg
// Description : Shared types and constants for the serial nibble matcher.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nibble_pkg;

  localparam logic [3:0] PATTERN_DEFAULT = 4'b0101;

  typedef logic [3:0] nibble_t;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    ARMED   = 2'd1,
    HOLDOFF = 2'd2
  } match_state_t;

endpackage

`default_nettype wire

// File: rtl/nibble_shift_reg.sv
// ============================================================================
// Module      : nibble_shift_reg
// Description : 4-bit serial-in shift window with a saturating 0..4 fill count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_shift_reg
  import nibble_pkg::*;
(
  input  logic    clk_i,
  input  logic    reset_i,
  input  logic    clear_i,
  input  logic    bit_in_i,
  input  logic    bit_valid_i,
  output nibble_t window_o,
  output logic    window_valid_o
);

  nibble_t    window_q;
  nibble_t    window_d;
  logic [2:0] fill_q;
  logic [2:0] fill_d;
  logic       window_valid_q;

  always_comb begin
    window_d = window_q;
    fill_d   = fill_q;
    if (bit_valid_i) begin
      window_d = {window_q[2:0], bit_in_i};
      if (fill_q != 3'd4) begin
        fill_d = fill_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      window_q       <= '0;
      fill_q         <= '0;
      window_valid_q <= 1'b0;
    end else begin
      window_q       <= window_d;
      fill_q         <= fill_d;
      window_valid_q <= (fill_d == 3'd4);
    end
  end

  assign window_o       = window_q;
  assign window_valid_o = window_valid_q;

endmodule

`default_nettype wire

// File: rtl/serial_nibble_matcher.sv
// ============================================================================
// Module      : serial_nibble_matcher
// Description : Sliding 4-bit pattern detector with match pulse and saturating count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_nibble_matcher
  import nibble_pkg::*;
#(
  parameter nibble_t PATTERN = PATTERN_DEFAULT,
  parameter int      CNT_W   = 8,
  parameter int      OVERLAP = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             bit_in_i,
  input  logic             bit_valid_i,
  input  logic             clear_i,
  output nibble_t          window_o,
  output logic             window_valid_o,
  output logic             match_o,
  output logic [CNT_W-1:0] match_count_o
);

  localparam bit OVERLAP_EN = (OVERLAP != 0);

  nibble_t          window_w;
  nibble_t          next_window_w;
  logic             pattern_hit_w;
  match_state_t     state_q;
  match_state_t     state_d;
  logic [1:0]       bit_cnt_q;
  logic [1:0]       bit_cnt_d;
  logic             match_q;
  logic             match_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  nibble_shift_reg u_shift (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .clear_i        (clear_i),
    .bit_in_i       (bit_in_i),
    .bit_valid_i    (bit_valid_i),
    .window_o       (window_w),
    .window_valid_o (window_valid_o)
  );

  assign next_window_w = {window_w[2:0], bit_in_i};
  assign pattern_hit_w = (next_window_w == PATTERN);

  // bit_cnt_q counts accepted bits while filling and while held off.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    match_d   = 1'b0;
    if (bit_valid_i) begin
      case (state_q)
        FILL: begin
          bit_cnt_d = bit_cnt_q + 2'd1;
          if (bit_cnt_q == 2'd3) begin
            state_d   = ARMED;
            bit_cnt_d = 2'd0;
            match_d   = pattern_hit_w;
            if (pattern_hit_w && !OVERLAP_EN) begin
              state_d = HOLDOFF;
            end
          end
        end
        ARMED: begin
          if (pattern_hit_w) begin
            match_d = 1'b1;
            if (!OVERLAP_EN) begin
              state_d   = HOLDOFF;
              bit_cnt_d = 2'd0;
            end
          end
        end
        HOLDOFF: begin
          bit_cnt_d = bit_cnt_q + 2'd1;
          if (bit_cnt_q == 2'd3) begin
            state_d   = ARMED;
            bit_cnt_d = 2'd0;
            if (pattern_hit_w) begin
              match_d = 1'b1;
              state_d = HOLDOFF;
            end
          end
        end
        default: begin
          state_d   = FILL;
          bit_cnt_d = 2'd0;
        end
      endcase
    end else if (state_q != FILL && state_q != ARMED && state_q != HOLDOFF) begin
      state_d   = FILL;
      bit_cnt_d = 2'd0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (match_d && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      state_q   <= FILL;
      bit_cnt_q <= 2'd0;
      match_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      match_q   <= match_d;
      count_q   <= count_d;
    end
  end

  assign window_o      = window_w;
  assign match_o       = match_q;
  assign match_count_o = count_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_nibble_matcher.sv
// ============================================================================
// Module      : tb_serial_nibble_matcher
// Description : Directed self-checking bench; overlap, non-overlap and saturating variants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_nibble_matcher;

  logic       clk;
  logic       reset;
  logic       bit_in;
  logic       bit_valid;
  logic       clear;

  logic [3:0] ov_window, no_window, sat_window;
  logic       ov_wv, no_wv, sat_wv;
  logic       ov_match, no_match, sat_match;
  logic [7:0] ov_count, no_count;
  logic [1:0] sat_count;

  int checks = 0;
  int fails  = 0;

  serial_nibble_matcher #(.CNT_W(8), .OVERLAP(1)) u_ov (
    .clk_i(clk), .reset_i(reset), .bit_in_i(bit_in), .bit_valid_i(bit_valid),
    .clear_i(clear), .window_o(ov_window), .window_valid_o(ov_wv),
    .match_o(ov_match), .match_count_o(ov_count)
  );

  serial_nibble_matcher #(.CNT_W(8), .OVERLAP(0)) u_no (
    .clk_i(clk), .reset_i(reset), .bit_in_i(bit_in), .bit_valid_i(bit_valid),
    .clear_i(clear), .window_o(no_window), .window_valid_o(no_wv),
    .match_o(no_match), .match_count_o(no_count)
  );

  serial_nibble_matcher #(.CNT_W(2), .OVERLAP(0)) u_sat (
    .clk_i(clk), .reset_i(reset), .bit_in_i(bit_in), .bit_valid_i(bit_valid),
    .clear_i(clear), .window_o(sat_window), .window_valid_o(sat_wv),
    .match_o(sat_match), .match_count_o(sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one edge's inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic b, input logic c, input logic r);
    @(negedge clk);
    bit_valid = v;
    bit_in    = b;
    clear     = c;
    reset     = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;

    // Reset with random data on the inputs
    step(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    step(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    check("rst_window", {28'd0, ov_window}, 32'h0);
    check("rst_wv",     {31'd0, ov_wv},     32'h0);
    check("rst_match",  {31'd0, ov_match},  32'h0);
    check("rst_count",  {24'd0, ov_count},  32'h0);

    // Basic 0101
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("b1_match", {31'd0, ov_match}, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("b2_match", {31'd0, ov_match}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("b3_match", {31'd0, ov_match}, 32'h0);
    check("b3_wv",    {31'd0, ov_wv},    32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("b4_match",  {31'd0, ov_match}, 32'h1);
    check("b4_window", {28'd0, ov_window}, 32'h5);
    check("b4_wv",     {31'd0, ov_wv},    32'h1);
    check("b4_count",  {24'd0, ov_count}, 32'h1);
    check("b4_nomatch", {31'd0, no_match}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("b_pulse_end", {31'd0, ov_match}, 32'h0);

    // Overlap: continue with 01 -> stream 0101 01
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("ov6_match", {31'd0, ov_match}, 32'h1);
    check("ov6_count", {24'd0, ov_count}, 32'h2);
    check("no6_match", {31'd0, no_match}, 32'h0);
    check("no6_count", {24'd0, no_count}, 32'h1);
    // Extend to 0101 0101
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("no8_match", {31'd0, no_match}, 32'h1);
    check("no8_count", {24'd0, no_count}, 32'h2);
    check("ov8_count", {24'd0, ov_count}, 32'h3);

    // Gaps between bits of 0101
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_count", {24'd0, ov_count}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("gap_hold1", {28'd0, ov_window}, 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("gap_hold2", {28'd0, ov_window}, 32'h2);
    check("gap_nomatch", {31'd0, ov_match}, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("gap_match", {31'd0, ov_match}, 32'h1);
    check("gap_count", {24'd0, ov_count}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("gap_after", {31'd0, ov_match}, 32'h0);

    // Saturation on the 2-bit counter, five back-to-back 0101
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int rep = 0; rep < 5; rep++) begin
      logic [31:0] exp_cnt;
      exp_cnt = (rep < 3) ? 32'(rep + 1) : 32'd3;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("sat%0d_pre", rep), {31'd0, sat_match}, 32'h0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check($sformatf("sat%0d_match", rep), {31'd0, sat_match}, 32'h1);
      check($sformatf("sat%0d_count", rep), {30'd0, sat_count}, exp_cnt);
    end

    // Clear on the completing edge suppresses the match
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("clr_match",  {31'd0, ov_match},  32'h0);
    check("clr_window", {28'd0, ov_window}, 32'h0);
    check("clr_wv",     {31'd0, ov_wv},     32'h0);
    check("clr_cnt",    {24'd0, ov_count},  32'h0);

    // Reset and clear together
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("pre_rc_window", {28'd0, no_window}, 32'h3);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("rc_window", {28'd0, no_window}, 32'h0);
    check("rc_wv",     {31'd0, no_wv},     32'h0);
    check("rc_match",  {31'd0, no_match},  32'h0);
    check("rc_count",  {24'd0, no_count},  32'h0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

`default_nettype wire
